bus_fabric: RTL
===============

Name: bus_fabric

Overview:
- Parametrised single-master system bus fabric for the 8-bit computer: decodes CPU addresses into NUM_SLAVES memory-mapped regions (ROM, RAM, VDP register window, spare).
- Generates per-slave chip selects and programmable per-region wait states.
- Completes each access with a ready/ack handshake.
- Flags an error on unmapped or timed-out accesses.
- Replaces the implicit shared data wire between Cpu and the peripherals.

Parameters:
- NUM_SLAVES, 4, number of slave regions (1..8).
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- BASE, {16'h0000,16'h8000,16'h0000,16'hFFF0}, packed NUM_SLAVES*ADDR_W; slice i = base of slave i (slave 0 in LSBs: VDP FFF0, ROM 0000, RAM 8000, spare 0000).
- MASK, {16'hFFFF,16'h8000,16'h8000,16'hFFF0}, packed NUM_SLAVES*ADDR_W; slice i = compare mask of slave i (spare matches only 0000, shadowed by ROM).
- WAITS, {4'd0,4'd0,4'd0,4'd1}, packed NUM_SLAVES*4; minimum wait cycles per slave.
- TIMEOUT, 64, maximum cycles to wait for s_ready after the wait count expires.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- m_req  in  1  master request; m_addr/m_we/m_wdata held stable while m_req=1 until m_ack
- m_addr  in  ADDR_W  master address
- m_we  in  1  1=write, 0=read
- m_wdata  in  DATA_W  write data
- m_rdata  out  DATA_W  read data; valid in m_ack cycle, held until next m_ack
- m_ack  out  1  one-cycle completion pulse
- m_err  out  1  error qualifier; valid with m_ack, held with m_rdata
- m_busy  out  1  high in ACCESS and RESP
- s_cs  out  NUM_SLAVES  one-hot chip select
- s_we  out  1  write strobe, qualified by s_cs
- s_addr  out  ADDR_W  registered address
- s_wdata  out  DATA_W  registered write data
- s_rdata  in  NUM_SLAVES*DATA_W  per-slave read data, slice i = slave i
- s_ready  in  NUM_SLAVES  per-slave ready

Behaviour:
- Decode:
  - match_i = ((m_addr & MASK_i) == BASE_i).
  - Lowest index wins on overlap, so the VDP window at FFF0-FFFF overrides RAM.
  - No match = unmapped.
- States: IDLE, ACCESS, RESP.
- IDLE, m_req=1, mapped:
  - Register addr/we/wdata and sel=winning index.
  - Load wait_cnt=WAITS_sel; clear to_cnt.
  - Go to ACCESS.
- IDLE, m_req=1, unmapped:
  - Go to RESP with err=1 and rdata={DATA_W{1'b1}}.
  - No s_cs is asserted.
- ACCESS:
  - s_cs[sel]=1 and s_we=registered we every cycle.
  - If wait_cnt!=0: decrement.
  - Else if s_ready[sel]=1: capture s_rdata slice sel (reads only; writes leave m_rdata unchanged), err=0, go to RESP.
  - Else increment to_cnt.
  - If to_cnt reaches TIMEOUT-1 with ready low: go to RESP with err=1 and rdata all ones.
- RESP:
  - m_ack=1 for exactly one cycle; s_cs=0; then IDLE.
  - m_req is not sampled in RESP.
- Latency:
  - Mapped access with WAITS=0 and ready high: m_req sampled at cycle 0, s_cs cycle 1, m_ack cycle 2.
  - Each wait state adds 1 cycle.
  - Unmapped access: m_ack at cycle 1.
- Back-to-back: if m_req is still high in the IDLE cycle after m_ack, a new transaction starts. The master drops m_req in the cycle after m_ack to avoid a repeat.
- s_ready is ignored while wait_cnt!=0 and for non-selected slaves.
- s_cs is registered, glitch-free, and at most one bit is set.
- Changes on m_addr/m_we/m_wdata during ACCESS are ignored, because registered copies are used.
- Reset (including mid-access):
  - Next edge: state=IDLE; s_cs=0, s_we=0, m_ack=0, m_err=0, m_busy=0.
  - m_rdata=0, s_addr=0, s_wdata=0, counters=0.
  - No ack is issued for the aborted access.
- Widths: wait_cnt is 4 bits; to_cnt is $clog2(TIMEOUT+1) bits.

Test Plan:
- Read 16'h1234, slave1 (ROM), WAITS=0, s_ready=1, s_rdata slice1=8'hA5 -> s_cs=4'b0010 at cycle 1; m_ack at cycle 2 with m_rdata=8'hA5, m_err=0.
- Write 16'hFFF3 with 8'h3C -> decodes to VDP (s_cs=4'b0001, not RAM), s_we=1, s_wdata=8'h3C, s_addr=16'hFFF3 for 2 cycles (WAITS=1); m_ack at cycle 3.
- RAM read 16'h8000 with s_ready[2] low for 5 cycles after waits -> s_cs held for 6 cycles; m_ack follows the first ready-high cycle; m_err=0.
- s_ready[1] stuck low, TIMEOUT=64 -> m_ack after exactly 64 ACCESS cycles with m_err=1 and m_rdata=8'hFF; s_cs then 0.
- Override MASK slice3=16'hF000, BASE slice3=16'h7000, ROM MASK=16'hC000; read 16'h5000 -> unmapped: no s_cs, m_ack at cycle 1, m_err=1, m_rdata=8'hFF.
- Assert reset during ACCESS with WAITS=3 -> next edge s_cs=0, m_busy=0, no m_ack; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/bus_fabric.sv
// Single-master system bus fabric: address decode, registered chip selects,
// per-region wait states, ready/ack handshake and error on unmapped/timed-out access.
module bus_fabric #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE = {16'h0000, 16'h8000, 16'h0000, 16'hFFF0},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] MASK = {16'hFFFF, 16'h8000, 16'h8000, 16'hFFF0},
  parameter logic [NUM_SLAVES*4-1:0] WAITS = {4'd0, 4'd0, 4'd0, 4'd1},
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         m_req,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic                         m_we,
  input  logic [DATA_W-1:0]            m_wdata,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_ack,
  output logic                         m_err,
  output logic                         m_busy,
  output logic [NUM_SLAVES-1:0]        s_cs,
  output logic                         s_we,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ready
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state, state_nxt;
  logic [SEL_W-1:0]      sel, sel_nxt;
  logic [ADDR_W-1:0]     addr_q, addr_nxt;
  logic                  we_q, we_nxt;
  logic [DATA_W-1:0]     wdata_q, wdata_nxt;
  logic [3:0]            wait_cnt, wait_nxt;
  logic [TO_W-1:0]       to_cnt, to_nxt;
  logic [NUM_SLAVES-1:0] cs_q, cs_nxt;
  logic [DATA_W-1:0]     rdata_q, rdata_nxt;
  logic                  err_q, err_nxt;
  logic                  hit;
  logic [SEL_W-1:0]      hit_idx;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    addr_nxt  = addr_q;
    we_nxt    = we_q;
    wdata_nxt = wdata_q;
    wait_nxt  = wait_cnt;
    to_nxt    = to_cnt;
    cs_nxt    = cs_q;
    rdata_nxt = rdata_q;
    err_nxt   = err_q;
    case (state)
      IDLE: begin
        if (m_req) begin
          if (hit) begin
            state_nxt       = ACCESS;
            sel_nxt         = hit_idx;
            addr_nxt        = m_addr;
            we_nxt          = m_we;
            wdata_nxt       = m_wdata;
            wait_nxt        = WAITS[int'(hit_idx)*4 +: 4];
            to_nxt          = '0;
            cs_nxt          = '0;
            cs_nxt[hit_idx] = 1'b1;
          end else begin
            state_nxt = RESP;
            err_nxt   = 1'b1;
            rdata_nxt = {DATA_W{1'b1}};
          end
        end
      end
      ACCESS: begin
        if (wait_cnt != 4'd0) begin
          wait_nxt = wait_cnt - 4'd1;
        end else if (s_ready[sel]) begin
          if (!we_q) rdata_nxt = s_rdata[int'(sel)*DATA_W +: DATA_W];
          err_nxt   = 1'b0;
          cs_nxt    = '0;
          state_nxt = RESP;
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          rdata_nxt = {DATA_W{1'b1}};
          cs_nxt    = '0;
          state_nxt = RESP;
        end else begin
          to_nxt = to_cnt + TO_W'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sel      <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wait_cnt <= '0;
      to_cnt   <= '0;
      cs_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      addr_q   <= addr_nxt;
      we_q     <= we_nxt;
      wdata_q  <= wdata_nxt;
      wait_cnt <= wait_nxt;
      to_cnt   <= to_nxt;
      cs_q     <= cs_nxt;
      rdata_q  <= rdata_nxt;
      err_q    <= err_nxt;
    end
  end

  assign m_ack   = (state == RESP);
  assign m_busy  = (state != IDLE);
  assign m_rdata = rdata_q;
  assign m_err   = err_q;
  assign s_cs    = cs_q;
  assign s_we    = (state == ACCESS) && we_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;

endmodule
